// File: rtl/spi_host_pkg.sv
// spi_host_pkg: shared types and helpers for the spi_host_mc SPI host.
//   state_t    : host FSM states.
//   cs_width   : width of a chip-select index (at least one bit).
//   pack_entry : builds a FIFO entry {last, cs, data}; the caller casts the
//                result to the entry width. Fields are limited to 32 bits each.
package spi_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_STALL = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

  // Last flag sits above cs, cs sits above data.
  function automatic logic [63:0] pack_entry(input logic        last,
                                             input logic [31:0] cs,
                                             input logic [31:0] data,
                                             input int          cs_w,
                                             input int          data_w);
    logic [63:0] e;
    e = {63'd0, last} << (cs_w + data_w);
    e = e | ({32'd0, cs} << data_w);
    e = e | {32'd0, data};
    return e;
  endfunction

endpackage

// File: rtl/spi_host_mc_fifo.sv
// spi_fifo: synchronous FIFO with occupancy count, full and empty flags.
//   clk, rst        : clock and synchronous active-high reset (flushes FIFO).
//   push_i, wdata_i : write request and data; ignored when full.
//   pop_i, rdata_o  : read request and head-of-queue data; pop ignored when empty.
//   count_o         : number of stored entries (0..DEPTH).
//   full_o, empty_o : occupancy flags derived from the count register.
module spi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == CNT_W'(0));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Next pointer and count values; pointers wrap at DEPTH, which need not be a power of two.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push_s) begin
      wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_q + PTR_W'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_q + PTR_W'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= PTR_W'(0);
      rd_q    <= PTR_W'(0);
      count_q <= CNT_W'(0);
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/spi_host_mc.sv
// spi_host_mc: buffered multi-chip-select SPI host with frame delimiting.
//   clk, rst      : clock and synchronous active-high reset.
//   load_iv/id/cs/last, load_ready : upstream word interface with backpressure.
//   clk_out       : serial clock, idles at CPOL.
//   sel_out       : active-low chip selects, one asserted per frame.
//   data_out      : DATA_WIDTH-lane parallel data, one word per clk_out period.
//   busy          : high while the FSM is not idle.
//   overflow      : one-cycle pulse after a word was dropped on a full FIFO.
//   underrun      : one-cycle pulse when a frame stalls on an empty FIFO.
// DATA_WIDTH is limited to 32 by the entry packing helper.
module spi_host_mc
  import spi_host_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_DUR    = 2,
  parameter int BYTE_STORE = 20,
  parameter int NUM_CS     = 2,
  parameter bit CPOL       = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_iv,
  input  logic [DATA_WIDTH-1:0]                load_id,
  input  logic [spi_host_pkg::cs_width(NUM_CS)-1:0] load_cs,
  input  logic                                 load_last,
  output logic                                 load_ready,
  output logic                                 clk_out,
  output logic [NUM_CS-1:0]                    sel_out,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic                                 busy,
  output logic                                 overflow,
  output logic                                 underrun
);

  localparam int CS_W    = cs_width(NUM_CS);
  localparam int ENTRY_W = 1 + CS_W + DATA_WIDTH;
  localparam int FCNT_W  = $clog2(BYTE_STORE + 1);
  localparam int HC_W    = (BIT_DUR > 1) ? $clog2(BIT_DUR) : 1;

  state_t                state_q, state_d;
  logic [HC_W-1:0]       cnt_q, cnt_d;
  logic                  clk_q, clk_d;
  logic [NUM_CS-1:0]     sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CS_W-1:0]       cs_q, cs_d;
  logic                  last_q, last_d;
  logic                  busy_q, ovf_q, und_q, und_d;
  logic [FCNT_W-1:0]     pend_q, pend_d;

  logic                  push_s, pop_s, half_done_s;
  logic [ENTRY_W-1:0]    entry_s, head_s;
  logic [FCNT_W-1:0]     fifo_count_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [CS_W-1:0]       head_cs_s;
  logic                  head_last_s;

  assign load_ready  = (fifo_count_s != FCNT_W'(BYTE_STORE));
  assign push_s      = load_iv && load_ready;
  assign entry_s     = ENTRY_W'(pack_entry(load_last, 32'(load_cs), 32'(load_id), CS_W, DATA_WIDTH));
  assign head_data_s = head_s[DATA_WIDTH-1:0];
  assign head_cs_s   = head_s[DATA_WIDTH +: CS_W];
  assign head_last_s = head_s[ENTRY_W-1];
  assign half_done_s = (cnt_q == HC_W'(BIT_DUR - 1));

  spi_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BYTE_STORE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i (entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Frame FSM: sequences LOW/HIGH half-periods per word and the frame delimiting phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cs_d    = cs_q;
    last_d  = last_q;
    pop_s   = 1'b0;
    und_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A FIFO filled without any last word must still drain, so full also starts a frame.
        if ((pend_q != FCNT_W'(0)) || fifo_full_s) begin
          pop_s   = 1'b1;
          state_d = ST_LOW;
          cnt_d   = HC_W'(0);
          clk_d   = CPOL;
          data_d  = head_data_s;
          cs_d    = head_cs_s;
          last_d  = head_last_s;
          sel_d   = ~(NUM_CS'(1) << head_cs_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (half_done_s) begin
          state_d = ST_HIGH;
          cnt_d   = HC_W'(0);
          clk_d   = ~CPOL;
        end else begin
          cnt_d = cnt_q + HC_W'(1);
        end
      end
      ST_HIGH: begin
        if (half_done_s) begin
          cnt_d = HC_W'(0);
          clk_d = CPOL;
          if (last_q) begin
            state_d = ST_HOLD;
          end else if (!fifo_empty_s) begin
            // Chip select stays latched from the frame's first word.
            pop_s   = 1'b1;
            state_d = ST_LOW;
            data_d  = head_data_s;
            last_d  = head_last_s;
          end else begin
            state_d = ST_STALL;
            und_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + HC_W'(1);
        end
      end
      ST_STALL: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_LOW;
          cnt_d   = HC_W'(0);
          data_d  = head_data_s;
          last_d  = head_last_s;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_HOLD: begin
        if (half_done_s) begin
          state_d = ST_GAP;
          cnt_d   = HC_W'(0);
          sel_d   = {NUM_CS{1'b1}};
        end else begin
          cnt_d = cnt_q + HC_W'(1);
        end
      end
      ST_GAP: begin
        if (half_done_s) begin
          state_d = ST_IDLE;
          cnt_d   = HC_W'(0);
        end else begin
          cnt_d = cnt_q + HC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = HC_W'(0);
        clk_d   = CPOL;
        sel_d   = {NUM_CS{1'b1}};
      end
    endcase
  end

  // Complete-frame counter; a push and pop of last words in one cycle cancel out.
  always_comb begin
    case ({push_s && load_last, pop_s && head_last_s})
      2'b10:   pend_d = pend_q + FCNT_W'(1);
      2'b01:   pend_d = pend_q - FCNT_W'(1);
      default: pend_d = pend_q;
    endcase
  end

  // State and output registers; reset aborts any frame without hold or gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= HC_W'(0);
      clk_q   <= CPOL;
      sel_q   <= {NUM_CS{1'b1}};
      data_q  <= DATA_WIDTH'(0);
      cs_q    <= CS_W'(0);
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
      pend_q  <= FCNT_W'(0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      last_q  <= last_d;
      busy_q  <= (state_d != ST_IDLE);
      ovf_q   <= load_iv && !load_ready;
      und_q   <= und_d;
      pend_q  <= pend_d;
    end
  end

  assign clk_out  = clk_q;
  assign sel_out  = sel_q;
  assign data_out = data_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign underrun = und_q;

endmodule
